// File: rtl/acq_scheduler.sv
// ---------------------------------------------------------------------------
// acq_scheduler
//   Sequences a full 32-PRN acquisition search. For each of eight groups of
//   four PRNs it launches the correlator engine once per Doppler bin. While
//   each launch runs it keeps the strongest result per lane. At the end of a
//   group it reports the lanes whose peak reaches the detection threshold.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   scan_req, scan_abort        start / terminate a scan
//   threshold                   detection threshold, latched at scan start
//   busy, scan_done             scan in progress / one-cycle completion pulse
//   eng_start                   one-cycle engine launch pulse
//   eng_sat_base, eng_doppler   PRN group base and Doppler omega of the launch
//   eng_done                    engine finished the current launch
//   res_valid, res_phase,
//   res_corr                    per-code-phase results, four 12-bit lanes
//   det_valid, det_ready        detection record handshake
//   det_prn, det_phase,
//   det_doppler, det_peak       detection record fields
// ---------------------------------------------------------------------------
module acq_scheduler #(
    parameter int                 NUM_BINS      = 8,
    parameter logic signed [15:0] DOPPLER_START = -16'sd400,
    parameter logic signed [15:0] DOPPLER_STEP  = 16'sd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_req,
    input  logic        scan_abort,
    input  logic [11:0] threshold,
    output logic        busy,
    output logic        scan_done,
    output logic        eng_start,
    output logic [5:0]  eng_sat_base,
    output logic [15:0] eng_doppler,
    input  logic        eng_done,
    input  logic        res_valid,
    input  logic [9:0]  res_phase,
    input  logic [47:0] res_corr,
    output logic        det_valid,
    input  logic        det_ready,
    output logic [5:0]  det_prn,
    output logic [9:0]  det_phase,
    output logic [15:0] det_doppler,
    output logic [11:0] det_peak
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT, S_NEXT} state_t;

    localparam logic [3:0] BIN_LAST = 4'(NUM_BINS - 1);

    state_t      state_q;
    logic [2:0]  group_q;
    logic [3:0]  bin_q;
    logic [1:0]  lane_q;
    logic [11:0] thr_q;
    logic        busy_q, done_q, start_q;
    logic [5:0]  base_q;
    logic [15:0] eng_dop_q;

    logic [11:0] peak_q  [4];
    logic [9:0]  phase_q [4];
    logic [15:0] dop_q   [4];
    logic [11:0] peak_d  [4];
    logic [9:0]  phase_d [4];
    logic [15:0] dop_d   [4];

    logic        det_valid_q;
    logic [5:0]  det_prn_q;
    logic [9:0]  det_phase_q;
    logic [15:0] det_dop_q;
    logic [11:0] det_peak_q;

    // Lane record to be presented next: lane 0 when entering REPORT, else the
    // lane after the one just completed.
    logic [1:0]  ld_lane;
    logic        ld_hit;

    // Peak tracking. The _d arrays already include a result arriving in the
    // same cycle as eng_done, so REPORT sees the fully updated lanes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        for (int k = 0; k < 4; k++) begin
            peak_d[k]  = peak_q[k];
            phase_d[k] = phase_q[k];
            dop_d[k]   = dop_q[k];
            // Strict compare: ties keep the earlier record.
            if (state_q == S_WAIT && res_valid && res_corr[12*k +: 12] > peak_q[k]) begin
                peak_d[k]  = res_corr[12*k +: 12];
                phase_d[k] = res_phase;
                dop_d[k]   = eng_dop_q;
            end
        end
        ld_lane = (state_q == S_REPORT) ? lane_q + 2'd1 : 2'd0;
        ld_hit  = peak_d[ld_lane] >= thr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            group_q     <= '0;
            bin_q       <= '0;
            lane_q      <= '0;
            thr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            base_q      <= 6'd1;
            eng_dop_q   <= DOPPLER_START;
            // NOTE: the per-lane arrays are small register files with defined reset values, so they are reset like any other state.
            peak_q      <= '{default: '0};
            phase_q     <= '{default: '0};
            dop_q       <= '{default: '0};
            det_valid_q <= 1'b0;
            det_prn_q   <= '0;
            det_phase_q <= '0;
            det_dop_q   <= '0;
            det_peak_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; later assignments override these defaults.
            start_q <= 1'b0;
            done_q  <= 1'b0;
            peak_q  <= peak_d;
            phase_q <= phase_d;
            dop_q   <= dop_d;

            if (scan_abort && state_q != S_IDLE) begin
                // Abort bypasses the record handshake and suppresses scan_done.
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                det_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (scan_req) begin
                            thr_q     <= threshold;
                            group_q   <= '0;
                            bin_q     <= '0;
                            peak_q    <= '{default: '0};
                            base_q    <= 6'd1;
                            eng_dop_q <= DOPPLER_START;
                            busy_q    <= 1'b1;
                            start_q   <= 1'b1;
                            state_q   <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: state_q <= S_WAIT;
                    S_WAIT: begin
                        if (eng_done) begin
                            if (bin_q != BIN_LAST) begin
                                bin_q     <= bin_q + 4'd1;
                                eng_dop_q <= eng_dop_q + DOPPLER_STEP;
                                start_q   <= 1'b1;
                                state_q   <= S_LAUNCH;
                            end else begin
                                lane_q      <= 2'd0;
                                det_valid_q <= ld_hit;
                                state_q     <= S_REPORT;
                            end
                        end
                    end
                    S_REPORT: begin
                        // A lane completes on a handshake, or at once if it is below threshold.
                        if (!det_valid_q || det_ready) begin
                            if (lane_q == 2'd3) begin
                                det_valid_q <= 1'b0;
                                state_q     <= S_NEXT;
                            end else begin
                                lane_q      <= ld_lane;
                                det_valid_q <= ld_hit;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (group_q != 3'd7) begin
                            group_q   <= group_q + 3'd1;
                            bin_q     <= '0;
                            peak_q    <= '{default: '0};
                            base_q    <= base_q + 6'd4;
                            eng_dop_q <= DOPPLER_START;
                            start_q   <= 1'b1;
                            state_q   <= S_LAUNCH;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end

            // Record fields are loaded whenever a new lane is presented.
            if ((state_q == S_WAIT && eng_done && bin_q == BIN_LAST) ||
                (state_q == S_REPORT && (!det_valid_q || det_ready) && lane_q != 2'd3)) begin
                det_prn_q   <= base_q + {4'd0, ld_lane};
                det_phase_q <= phase_d[ld_lane];
                det_dop_q   <= dop_d[ld_lane];
                det_peak_q  <= peak_d[ld_lane];
            end
        end
    end

    assign busy         = busy_q;
    assign scan_done    = done_q;
    assign eng_start    = start_q;
    assign eng_sat_base = base_q;
    assign eng_doppler  = eng_dop_q;
    assign det_valid    = det_valid_q;
    assign det_prn      = det_prn_q;
    assign det_phase    = det_phase_q;
    assign det_doppler  = det_dop_q;
    assign det_peak     = det_peak_q;

endmodule

// File: tb/tb_acq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_acq_scheduler
//   Drives acq_scheduler (NUM_BINS=2) with an engine model that answers each
//   launch with a list of results, and a record consumer with stalls. The
//   reference keeps the best result per PRN and derives the expected
//   detection list in ascending PRN order.
// ---------------------------------------------------------------------------
module tb_acq_scheduler;

    localparam int NB = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_req, scan_abort;
    logic [11:0] threshold;
    logic        busy, scan_done, eng_start;
    logic [5:0]  eng_sat_base;
    logic [15:0] eng_doppler;
    logic        eng_done, res_valid;
    logic [9:0]  res_phase;
    logic [47:0] res_corr;
    logic        det_valid, det_ready;
    logic [5:0]  det_prn;
    logic [9:0]  det_phase;
    logic [15:0] det_doppler;
    logic [11:0] det_peak;

    acq_scheduler #(.NUM_BINS(NB)) dut (
        .clk(clk), .rst(rst), .scan_req(scan_req), .scan_abort(scan_abort),
        .threshold(threshold), .busy(busy), .scan_done(scan_done),
        .eng_start(eng_start), .eng_sat_base(eng_sat_base), .eng_doppler(eng_doppler),
        .eng_done(eng_done), .res_valid(res_valid), .res_phase(res_phase),
        .res_corr(res_corr), .det_valid(det_valid), .det_ready(det_ready),
        .det_prn(det_prn), .det_phase(det_phase), .det_doppler(det_doppler),
        .det_peak(det_peak)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  ph;
        logic [47:0] corr;
    } res_t;

    typedef struct packed {
        logic [5:0]  prn;
        logic [9:0]  ph;
        logic [15:0] dop;
        logic [11:0] pk;
    } rec_t;

    int checks = 0;
    int errors = 0;

    // Reference state: best result per PRN over the current scan.
    int          best_peak [1:32];
    int          best_ph   [1:32];
    logic [15:0] best_dop  [1:32];
    int          thr_cur;
    rec_t        exp_q[$];
    res_t        rq[$];
    int          n_det;

    int ctab[5] = '{500, 2000, 3000, 3500, 4095};
    int ttab[3] = '{2000, 3000, 3500};

    localparam logic [47:0] ALL100 = {4{12'd100}};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_dop(input int n);
        return 16'(-400 + 100 * (n % NB));
    endfunction

    function automatic logic [5:0] exp_base(input int n);
        return 6'(1 + 4 * (n / NB));
    endfunction

    task automatic gen_results(input int scen, input int n);
        int g;
        g = n / NB;
        rq.delete();
        case (scen)
            0: repeat (3) rq.push_back({10'($urandom), 48'd0});
            1: begin
                rq.push_back({10'd5, ALL100});
                if (n == 1) rq.push_back({10'd517, {12'd100, 12'd3000, 12'd100, 12'd100}});
                rq.push_back({10'd700, ALL100});
            end
            2: begin
                if (n == 0) rq.push_back({10'd10,  {12'd100, 12'd100, 12'd100, 12'd2500}});
                if (n == 1) rq.push_back({10'd900, {12'd100, 12'd100, 12'd100, 12'd2500}});
                rq.push_back({10'd3, ALL100});
            end
            3: begin
                if (g == 7) rq.push_back({10'(100 + n), {12'd2400, 12'd2300, 12'd2200, 12'd2100}});
                else        rq.push_back({10'd50, ALL100});
            end
            default: begin
                int cnt;
                cnt = $urandom_range(0, 4);
                for (int i = 0; i < cnt; i++) begin
                    res_t r;
                    r.ph = 10'($urandom);
                    for (int k = 0; k < 4; k++)
                        r.corr[12*k +: 12] = 12'(ctab[$urandom_range(0, 4)]);
                    rq.push_back(r);
                end
            end
        endcase
    endtask

    task automatic apply_res(input int n, input res_t r);
        for (int k = 0; k < 4; k++) begin
            int p, c;
            p = 1 + 4 * (n / NB) + k;
            c = int'(r.corr[12*k +: 12]);
            if (c > best_peak[p]) begin
                best_peak[p] = c;
                best_ph[p]   = int'(r.ph);
                best_dop[p]  = exp_dop(n);
            end
        end
    endtask

    task automatic build_records(input int g);
        for (int k = 0; k < 4; k++) begin
            int p;
            rec_t e;
            p = 1 + 4 * g + k;
            if (best_peak[p] >= thr_cur) begin
                e.prn = 6'(p);
                e.ph  = 10'(best_ph[p]);
                e.dop = best_dop[p];
                e.pk  = 12'(best_peak[p]);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy,         1'b0);
        check({tag, "_done"},      scan_done,    1'b0);
        check({tag, "_start"},     eng_start,    1'b0);
        check({tag, "_det_valid"}, det_valid,    1'b0);
        check({tag, "_base"},      eng_sat_base, 6'd1);
        check({tag, "_dop"},       eng_doppler,  16'hFE70);
    endtask

    // One scan. stall_mode < 0 gives random det_ready stalls. abort_launch >= 0
    // aborts in the WAIT following that launch. rst_on_valid resets the DUT
    // when the first record appears.
    task automatic run_scan(input int scen, input int thr, input int stall_mode,
                            input int abort_launch, input bit rst_on_valid);
        int   launch, cur, cyc, stall;
        bit   eng_active, coincide, abort_pending, aborted, done, rec_open, drv;
        logic [43:0] held;

        for (int p = 1; p <= 32; p++) begin
            best_peak[p] = 0;
            best_ph[p]   = 0;
            best_dop[p]  = '0;
        end
        exp_q.delete();
        thr_cur = thr;
        n_det = 0;
        launch = 0; cur = 0; cyc = 0; stall = 0;
        eng_active = 0; coincide = 0; abort_pending = 0; aborted = 0; done = 0; rec_open = 0;
        held = '0;

        threshold = 12'(thr);
        scan_req  = 1'b1;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            scan_req = 1'b0; scan_abort = 1'b0; res_valid = 1'b0; eng_done = 1'b0;
            res_phase = '0; res_corr = '0; det_ready = 1'b0;
            threshold = 12'($urandom);

            if (aborted) begin
                int dones;
                check("abort_busy", busy, 1'b0);
                check("abort_det_valid", det_valid, 1'b0);
                check("abort_start", eng_start, 1'b0);
                dones = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (scan_done) dones++;
                end
                check("abort_no_done", dones, 0);
                return;
            end
            if (cyc == 1) check("busy_start", busy, 1'b1);
            if (cyc > 3000) begin
                check("scan_timeout", 1'b0, 1'b1);
                return;
            end
            if (scan_done) begin
                done = 1;
                break;
            end

            // Record consumer
            if (det_valid) begin
                if (!rec_open) begin
                    n_det++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_det", det_prn, 6'd0);
                    end else begin
                        rec_t e;
                        e = exp_q.pop_front();
                        check("det_prn",     det_prn,     e.prn);
                        check("det_phase",   det_phase,   e.ph);
                        check("det_doppler", det_doppler, e.dop);
                        check("det_peak",    det_peak,    e.pk);
                    end
                    held     = {det_prn, det_phase, det_doppler, det_peak};
                    rec_open = 1;
                    stall    = (stall_mode < 0) ? $urandom_range(0, 2) : stall_mode;
                end else begin
                    check("det_stable", {det_prn, det_phase, det_doppler, det_peak}, held);
                end
                if (rst_on_valid) begin
                    #2 rst = 1'b0;
                    #1 check_reset_outputs("async_rst");
                    @(posedge clk); #1;
                    rst = 1'b1;
                    @(posedge clk); #1;
                    check("post_rst_busy", busy, 1'b0);
                    check("post_rst_start", eng_start, 1'b0);
                    return;
                end
                det_ready = (stall == 0);
                if (stall > 0) stall--;
                if (det_ready) rec_open = 0;
            end else begin
                det_ready = 1'($urandom);
            end

            // Engine model
            drv = 0;
            if (eng_start) begin
                check("launch_base", eng_sat_base, exp_base(launch));
                check("launch_dop",  eng_doppler,  exp_dop(launch));
                cur = launch;
                launch++;
                gen_results(scen, cur);
                eng_active = 1;
                coincide   = (scen >= 4) ? 1'($urandom) : 1'b0;
                // Result outside WAIT: must be ignored.
                res_valid  = 1'b1;
                res_phase  = 10'($urandom);
                res_corr   = '1;
                if (cur == abort_launch) abort_pending = 1;
            end else if (abort_pending) begin
                scan_abort = 1'b1;
                eng_active = 0;
                aborted    = 1;
            end else if (eng_active) begin
                check("hold_base", eng_sat_base, exp_base(cur));
                check("hold_dop",  eng_doppler,  exp_dop(cur));
                if (rq.size() > 0) begin
                    res_t r;
                    r = rq.pop_front();
                    res_valid = 1'b1;
                    res_phase = r.ph;
                    res_corr  = r.corr;
                    apply_res(cur, r);
                    drv = 1;
                end
                if (rq.size() == 0 && (coincide || !drv)) begin
                    eng_done   = 1'b1;
                    eng_active = 0;
                    if (cur % NB == NB - 1) build_records(cur / NB);
                end
            end

            // Requests while busy must be ignored.
            if (busy && !scan_abort && $urandom_range(0, 39) == 0) scan_req = 1'b1;
        end

        check("scan_done_seen", done, 1'b1);
        check("launch_count", launch, 8 * NB);
        check("exp_drained", exp_q.size(), 0);
        case (scen)
            0: check("det_count_none", n_det, 0);
            1: check("det_count_one", n_det, 1);
            2: check("det_count_tie", n_det, 1);
            3: check("det_count_g7", n_det, 4);
            default: ;
        endcase
        @(posedge clk); #1;
        check("done_pulse_width", scan_done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        scan_req = 1'b0; scan_abort = 1'b0; threshold = '0;
        eng_done = 1'b0; res_valid = 1'b0; res_phase = '0; res_corr = '0;
        det_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        run_scan(0, 4095, 0, -1, 1'b0);   // all-zero results, no detections
        run_scan(1, 2000, -1, -1, 1'b0);  // single detection PRN 3
        run_scan(2, 2000, -1, -1, 1'b0);  // tie keeps earlier phase
        run_scan(3, 2000, 5, -1, 1'b0);   // group 7 all lanes, stalled consumer
        repeat (6) run_scan(4, ttab[$urandom_range(0, 2)], -1, -1, 1'b0);
        run_scan(4, 2000, -1, 6, 1'b0);   // abort in WAIT of group 3
        run_scan(0, 4095, 0, -1, 1'b0);   // restart after abort
        run_scan(1, 2000, 0, -1, 1'b1);   // reset while a record is valid
        run_scan(4, 3000, -1, -1, 1'b0);  // clean scan after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_scheduler.md
ACQ_SCHEDULER -- requirements
Module: acq_scheduler

Interface
REQ-001 Parameter NUM_BINS, default 8: Doppler bins searched per satellite group (1..16).
REQ-002 Parameter DOPPLER_START, default -16'sd400: signed Doppler omega of bin 0.
REQ-003 Parameter DOPPLER_STEP, default 16'sd100: signed omega increment per bin.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 scan_req  in  1  start a full 32-PRN scan when idle (single-cycle pulse).
REQ-007 scan_abort  in  1  terminate the scan in progress.
REQ-008 threshold  in  12  detection threshold, sampled at scan start.
REQ-009 busy  out  1  scan in progress.
REQ-010 scan_done  out  1  one-cycle pulse at scan completion.
REQ-011 eng_start  out  1  one-cycle launch pulse to the correlator engine.
REQ-012 eng_sat_base  out  6  first PRN of the current 4-PRN group (1,5,...,29).
REQ-013 eng_doppler  out  16  signed Doppler omega of the current bin.
REQ-014 eng_done  in  1  engine finished all 1023 code phases for the launch.
REQ-015 res_valid  in  1  one code-phase result present on res_phase/res_corr.
REQ-016 res_phase  in  10  code phase of the result.
REQ-017 res_corr  in  48  four 12-bit integrator values, lane k at [12k+11:12k].
REQ-018 det_valid / det_ready  out/in  1/1  detection record handshake.
REQ-019 det_prn / det_phase / det_doppler / det_peak  out  6/10/16/12  detection record fields.

Function
REQ-020 FSM states: IDLE, LAUNCH, WAIT, REPORT, NEXT; only IDLE has busy=0.
REQ-021 IDLE -> LAUNCH on scan_req; threshold latched, group=0, bin=0, lane peaks cleared, eng_doppler=DOPPLER_START.
REQ-022 LAUNCH: eng_start=1 for exactly one cycle, eng_sat_base=1+4*group; next state WAIT.
REQ-023 eng_sat_base and eng_doppler stay stable from LAUNCH until eng_done is received.
REQ-024 WAIT, res_valid=1: for each lane k, if res_corr lane k > peak_k (unsigned, strict), peak_k, phase_k and doppler_k are updated; ties keep the earlier record.
REQ-025 res_valid outside WAIT is ignored.
REQ-026 WAIT, eng_done=1: if bin<NUM_BINS-1, then bin+1, eng_doppler+=DOPPLER_STEP (16-bit two's-complement wrap), next LAUNCH; otherwise next REPORT with lane=0.
REQ-027 res_valid coincident with eng_done is applied before the transition.
REQ-028 REPORT: lane with peak_k >= threshold drives det_valid=1 with det_prn=eng_sat_base+k, det_phase=phase_k, det_doppler=doppler_k, det_peak=peak_k.
REQ-029 Record held stable while det_valid=1 and det_ready=0; lane advances on the cycle det_valid&det_ready.
REQ-030 Lanes below threshold are skipped, one cycle each, without det_valid.
REQ-031 After lane 3 completes, next NEXT.
REQ-032 NEXT, group<7: group+1, bin=0, peaks cleared, eng_doppler=DOPPLER_START, next LAUNCH.
REQ-033 NEXT, group=7: scan_done pulse, next IDLE.
REQ-034 scan_req while busy is ignored.
REQ-035 scan_abort (any non-IDLE state): next IDLE, det_valid drops immediately (the handshake rule is waived for abort), no scan_done; abort wins over coincident eng_done or det_ready.
REQ-036 Total launches per full scan = 8*NUM_BINS; detections emitted in ascending PRN order.

Reset
REQ-037 On rst low: state IDLE; busy, scan_done, eng_start, det_valid = 0; eng_sat_base=1; eng_doppler=DOPPLER_START; group, bin, lane, peaks, phases, dopplers, latched threshold = 0.
REQ-038 Reset mid-scan discards all progress; first cycle after release is IDLE.

Verification
REQ-039 NUM_BINS=2, threshold=4095, engine model returns all-zero results -> 16 eng_start pulses, sat_base 1,1,5,5,...,29,29, doppler alternating -400/-300, no det_valid, one scan_done.
REQ-040 Group 0, bin 1, phase 517, lane 2 = 3000, all else 100, threshold=2000 -> exactly one record: PRN 3, phase 517, doppler -300, peak 3000.
REQ-041 Two equal lane-0 peaks 2500 at phases 10 and 900, threshold 2000 -> det_phase=10.
REQ-042 All four lanes of group 7 above threshold, det_ready low for 5 cycles then high -> PRNs 29,30,31,32 in order, record stable while stalled, scan_done after the last handshake.
REQ-043 scan_abort during WAIT of group 3 -> IDLE next cycle, busy=0, no scan_done; new scan_req restarts at sat_base=1, doppler=-400.
REQ-044 rst asserted during REPORT with det_valid=1 -> all outputs at reset values immediately, asynchronously to clk.
